// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the dual-issue next-PC sequencer.
package pc_seq_pkg;
  localparam int PC_WIDTH       = 32;
  localparam int PC_SLOT_STRIDE = 4;
  localparam int PC_PAIR_STRIDE = 8;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    PEND  = 2'd3
  } pc_seq_state_t;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    TRAP     = 3'd1,
    EX0      = 3'd2,
    EX1      = 3'd3,
    DEC_PEND = 3'd4,
    DEC      = 3'd5
  } redirect_src_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect-request and fetch-address bundle between the front end and the PC sequencer.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
);
  logic             stall_F;
  logic             trap_valid;
  logic [WIDTH-1:0] trap_vector;
  logic             ex_redirect_valid_0;
  logic [WIDTH-1:0] ex_redirect_target_0;
  logic             ex_redirect_valid_1;
  logic [WIDTH-1:0] ex_redirect_target_1;
  logic             dec_redirect_valid;
  logic [WIDTH-1:0] dec_redirect_target;
  logic [WIDTH-1:0] PC_out_Pipeline_0;
  logic [WIDTH-1:0] PC_out_Pipeline_1;
  logic             fetch_valid;
  logic             flush_FD;
  logic             redirect_pending;
  logic             target_misaligned;

  modport master (
    output stall_F, trap_valid, trap_vector,
           ex_redirect_valid_0, ex_redirect_target_0,
           ex_redirect_valid_1, ex_redirect_target_1,
           dec_redirect_valid, dec_redirect_target,
    input  PC_out_Pipeline_0, PC_out_Pipeline_1,
           fetch_valid, flush_FD, redirect_pending, target_misaligned
  );

  modport slave (
    input  stall_F, trap_valid, trap_vector,
           ex_redirect_valid_0, ex_redirect_target_0,
           ex_redirect_valid_1, ex_redirect_target_1,
           dec_redirect_valid, dec_redirect_target,
    output PC_out_Pipeline_0, PC_out_Pipeline_1,
           fetch_valid, flush_FD, redirect_pending, target_misaligned
  );
endinterface

// File: rtl/pc_sequencer_redirect_arbiter.sv
// Fixed-priority redirect select: trap > ex0 > ex1 > parked decode > live decode.
module redirect_arbiter
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             en,
  input  logic             stall,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vector,
  input  logic             ex_valid_0,
  input  logic [WIDTH-1:0] ex_target_0,
  input  logic             ex_valid_1,
  input  logic [WIDTH-1:0] ex_target_1,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_target,
  input  logic             dec_valid,
  input  logic [WIDTH-1:0] dec_target,
  output redirect_src_t    src,
  output logic [WIDTH-1:0] target,
  output logic             accept
);

  // Priority chain; a parked entry masks any live decode request
  always_comb begin
    src    = NONE;
    target = {WIDTH{1'b0}};
    if (!en) begin
      src = NONE;
    end else if (trap_valid) begin
      src    = TRAP;
      target = trap_vector;
    end else if (ex_valid_0) begin
      src    = EX0;
      target = ex_target_0;
    end else if (ex_valid_1) begin
      src    = EX1;
      target = ex_target_1;
    end else if (pend_valid) begin
      if (!stall) begin
        src    = DEC_PEND;
        target = pend_target;
      end else begin
        src = NONE;
      end
    end else if (dec_valid && !stall) begin
      src    = DEC;
      target = dec_target;
    end else begin
      src = NONE;
    end
    accept = (src != NONE);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC pair, arbitrates redirects, parks stalled decode redirects.
module pc_sequencer #(
  parameter int               WIDTH    = pc_seq_pkg::PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  import pc_seq_pkg::*;

  pc_seq_state_t    state_r, state_s;
  logic [WIDTH-1:0] pc0_r, pc0_s, pc1_r;
  logic [WIDTH-1:0] pend_target_r, pend_target_s;
  logic             misaligned_r, misaligned_s;
  redirect_src_t    src_s;
  logic [WIDTH-1:0] target_s;
  logic             accept_s;

  redirect_arbiter #(.WIDTH(WIDTH)) u_arb (
    .en          (state_r != BOOT),
    .stall       (bus.stall_F),
    .trap_valid  (bus.trap_valid),
    .trap_vector (bus.trap_vector),
    .ex_valid_0  (bus.ex_redirect_valid_0),
    .ex_target_0 (bus.ex_redirect_target_0),
    .ex_valid_1  (bus.ex_redirect_valid_1),
    .ex_target_1 (bus.ex_redirect_target_1),
    .pend_valid  (state_r == PEND),
    .pend_target (pend_target_r),
    .dec_valid   (bus.dec_redirect_valid),
    .dec_target  (bus.dec_redirect_target),
    .src         (src_s),
    .target      (target_s),
    .accept      (accept_s)
  );

  // Next-state, next-PC and parking decisions
  always_comb begin
    state_s       = state_r;
    pc0_s         = pc0_r;
    pend_target_s = pend_target_r;
    misaligned_s  = misaligned_r;
    case (state_r)
      BOOT: state_s = RUN;
      RUN, STALL, PEND: begin
        if (src_s != NONE) begin
          state_s       = RUN;
          pc0_s         = {target_s[WIDTH-1:2], 2'b00};
          pend_target_s = {WIDTH{1'b0}};
          if (target_s[1:0] != 2'b00) begin
            misaligned_s = 1'b1;
          end else begin
            misaligned_s = misaligned_r;
          end
        end else if (state_r == PEND) begin
          state_s = PEND;
        end else if (bus.dec_redirect_valid && bus.stall_F) begin
          state_s       = PEND;
          pend_target_s = bus.dec_redirect_target;
        end else if (bus.stall_F) begin
          state_s = STALL;
        end else begin
          state_s = RUN;
          pc0_s   = pc0_r + WIDTH'(PC_PAIR_STRIDE);
        end
      end
      default: state_s = BOOT;
    endcase
  end

  // State, PC pair, parked target and sticky flag registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= BOOT;
      pc0_r         <= RESET_PC;
      pc1_r         <= RESET_PC + WIDTH'(PC_SLOT_STRIDE);
      pend_target_r <= {WIDTH{1'b0}};
      misaligned_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc0_r         <= pc0_s;
      pc1_r         <= pc0_s + WIDTH'(PC_SLOT_STRIDE);
      pend_target_r <= pend_target_s;
      misaligned_r  <= misaligned_s;
    end
  end

  assign bus.PC_out_Pipeline_0 = pc0_r;
  assign bus.PC_out_Pipeline_1 = pc1_r;
  assign bus.fetch_valid       = (state_r != BOOT);
  assign bus.redirect_pending  = (state_r == PEND);
  assign bus.flush_FD          = accept_s;
  assign bus.target_misaligned = misaligned_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a queue-based scoreboard checked at each falling edge.
module tb_pc_sequencer;
  logic clk;
  logic rst;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        fv;
    logic        fl;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int    compared   = 0;
  int    mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, compared away from the rising edge
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t  e;
      string n;
      e = sb_q.pop_front();
      n = name_q.pop_front();
      compared = compared + 1;
      if (bus.PC_out_Pipeline_0 !== e.pc0 || bus.PC_out_Pipeline_1 !== e.pc1 ||
          bus.fetch_valid !== e.fv || bus.flush_FD !== e.fl ||
          bus.redirect_pending !== e.pend || bus.target_misaligned !== e.mis) begin
        mismatched = mismatched + 1;
        $display("FAIL %s: got pc=%h/%h fv=%b fl=%b pend=%b mis=%b, expected pc=%h/%h fv=%b fl=%b pend=%b mis=%b",
                 n, bus.PC_out_Pipeline_0, bus.PC_out_Pipeline_1, bus.fetch_valid, bus.flush_FD,
                 bus.redirect_pending, bus.target_misaligned, e.pc0, e.pc1, e.fv, e.fl, e.pend, e.mis);
      end
    end
  end

  task automatic idle();
    bus.stall_F              = 1'b0;
    bus.trap_valid           = 1'b0;
    bus.trap_vector          = 32'h0;
    bus.ex_redirect_valid_0  = 1'b0;
    bus.ex_redirect_target_0 = 32'h0;
    bus.ex_redirect_valid_1  = 1'b0;
    bus.ex_redirect_target_1 = 32'h0;
    bus.dec_redirect_valid   = 1'b0;
    bus.dec_redirect_target  = 32'h0;
  endtask

  // Push the outputs expected during the current cycle, then advance one clock
  task automatic cyc(input string n, input logic [31:0] pc0, input logic fv,
                     input logic fl, input logic pend, input logic mis);
    exp_t e;
    e.pc0  = pc0;
    e.pc1  = pc0 + 32'd4;
    e.fv   = fv;
    e.fl   = fl;
    e.pend = pend;
    e.mis  = mis;
    sb_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    mismatched = mismatched + 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_hold", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Boot and sequential advance
    rst = 1'b1;
    cyc("boot", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("run0", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("run8", 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("run16", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);

    // Simultaneous trap/ex0/ex1: trap wins
    bus.trap_valid = 1'b1;          bus.trap_vector = 32'h100;
    bus.ex_redirect_valid_0 = 1'b1; bus.ex_redirect_target_0 = 32'h200;
    bus.ex_redirect_valid_1 = 1'b1; bus.ex_redirect_target_1 = 32'h300;
    cyc("all_redir_accept", 32'h18, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    cyc("trap_applied", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);

    // ex0 beats ex1
    bus.ex_redirect_valid_0 = 1'b1; bus.ex_redirect_target_0 = 32'h200;
    bus.ex_redirect_valid_1 = 1'b1; bus.ex_redirect_target_1 = 32'h300;
    cyc("ex_redir_accept", 32'h108, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    cyc("ex0_applied", 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);

    // Decode redirect parked under a 3-cycle stall; a newer decode is ignored
    bus.stall_F = 1'b1; bus.dec_redirect_valid = 1'b1; bus.dec_redirect_target = 32'h40;
    cyc("park", 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.dec_redirect_valid = 1'b0;
    cyc("parked1", 32'h208, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.dec_redirect_valid = 1'b1; bus.dec_redirect_target = 32'h60;
    cyc("parked2", 32'h208, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    cyc("pend_apply", 32'h208, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("pend_applied", 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);

    // Live decode redirect without stall
    bus.dec_redirect_valid = 1'b1; bus.dec_redirect_target = 32'h1000;
    cyc("dec_accept", 32'h48, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    cyc("dec_applied", 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Plain stall holds, then advance resumes
    bus.stall_F = 1'b1;
    cyc("stall1", 32'h1008, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("stall2", 32'h1008, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.stall_F = 1'b0;
    cyc("unstall", 32'h1008, 1'b1, 1'b0, 1'b0, 1'b0);

    // Parked redirect superseded by ex1 while still stalled
    bus.stall_F = 1'b1; bus.dec_redirect_valid = 1'b1; bus.dec_redirect_target = 32'h40;
    cyc("park2", 32'h1010, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.dec_redirect_valid = 1'b0;
    bus.ex_redirect_valid_1 = 1'b1; bus.ex_redirect_target_1 = 32'h80;
    cyc("ex1_over_pend", 32'h1010, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.ex_redirect_valid_1 = 1'b0;
    cyc("ex1_applied", 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.stall_F = 1'b0;
    cyc("no_stale_pend", 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("adv_after_super", 32'h88, 1'b1, 1'b0, 1'b0, 1'b0);

    // Wrap at top of address space
    bus.ex_redirect_valid_0 = 1'b1; bus.ex_redirect_target_0 = 32'hFFFF_FFF8;
    cyc("to_top", 32'h90, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    cyc("at_top", 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("wrapped", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Misaligned trap target: aligned PC, sticky flag
    bus.trap_valid = 1'b1; bus.trap_vector = 32'h103;
    cyc("mis_accept", 32'h8, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    cyc("mis_applied", 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("mis_sticky", 32'h108, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset while a decode redirect is parked
    bus.stall_F = 1'b1; bus.dec_redirect_valid = 1'b1; bus.dec_redirect_target = 32'h40;
    cyc("park3", 32'h110, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.dec_redirect_valid = 1'b0;
    cyc("parked3", 32'h110, 1'b1, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    cyc("rst_edge", 32'h110, 1'b1, 1'b0, 1'b1, 1'b1);
    bus.stall_F = 1'b0;
    cyc("rst_values", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("reboot", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("restart0", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("restart8", 32'h8, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      mismatched = mismatched + 1;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the dual-issue fetch stage. Owns the fetch PC pair (slot 0 / slot 1), advances it sequentially, and arbitrates redirect requests from trap logic, both execute pipelines and decode. Honours the fetch stall, and parks a decode redirect that arrives during a stall so it is never lost. Sits directly in front of the instruction-memory fetch ports and drives the F/D flush.

## Interface
- `WIDTH`, 32: PC / address width.
- `RESET_PC`, 32'h0: slot-0 fetch address after reset.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `stall_F`  in  1: hold the fetch PC pair this cycle.
- `trap_valid`  in  1: trap/exception redirect request.
- `trap_vector`  in  WIDTH: trap target.
- `ex_redirect_valid_0` / `ex_redirect_valid_1`  in  1: branch/jump resolve-redirect from execute pipeline 0 / 1.
- `ex_redirect_target_0` / `ex_redirect_target_1`  in  WIDTH: resolved targets.
- `dec_redirect_valid`  in  1: early (decode) jump redirect.
- `dec_redirect_target`  in  WIDTH: decode target.
- `PC_out_Pipeline_0` / `PC_out_Pipeline_1`  out  WIDTH: fetch addresses; slot 1 always equals slot 0 + 4.
- `fetch_valid`  out  1: fetch pair is real (low during boot).
- `flush_FD`  out  1: kill the pair currently in F/D.
- `redirect_pending`  out  1: a parked decode redirect exists.
- `target_misaligned`  out  1: sticky; an accepted target had bits [1:0] ≠ 0.

## Operation
- **States:** BOOT, RUN, STALL, PEND.
- **Reset:**
  - State goes to BOOT.
  - PC0 = RESET_PC, PC1 = RESET_PC+4.
  - `fetch_valid` = 0, `flush_FD` = 0, `redirect_pending` = 0, `target_misaligned` = 0.
  - Pending target register cleared.
- **BOOT:** → RUN after one cycle. PC unchanged; `fetch_valid` rises on entry to RUN.
- **Redirect priority (highest first):**
  - trap
  - ex slot 0 (older instruction)
  - ex slot 1
  - parked decode redirect
  - live decode redirect
- **Redirect overrides:**
  - Trap and ex redirects override `stall_F`.
  - A trap or ex redirect also discards any parked decode redirect.
- **Accepted redirect to target T:**
  - PC0 ← {T[WIDTH-1:2], 2'b00}, PC1 ← PC0+4.
  - `flush_FD` = 1 in the same (accept) cycle; it is combinational from the inputs and state.
  - If T[1:0] ≠ 0, `target_misaligned` is set and stays set until reset.
- **RUN:**
  - If a trap/ex redirect is present, accept it.
  - Else if `dec_redirect_valid` && !`stall_F`, accept the decode redirect.
  - Else if `dec_redirect_valid` && `stall_F`: latch the target, go to PEND.
  - Else if `stall_F`: go to STALL, hold PC.
  - Else advance: PC0 ← PC0+8, PC1 ← PC0+12.
- **STALL:** same rules as RUN. Return to RUN when `stall_F` = 0 and nothing is parked.
- **PEND:**
  - PC is held and `redirect_pending` = 1.
  - A new `dec_redirect_valid` while parked is ignored; the older parked redirect wins.
  - On the first cycle with `stall_F` = 0, apply the parked target and go to RUN.
  - A trap/ex redirect in PEND is accepted, clears the parked entry, and goes to RUN.
- **Arithmetic:** all PC arithmetic is modulo 2^WIDTH. Wrap from 32'hFFFF_FFF8 gives PC0 = 0, PC1 = 4, with no error.
- **Reset mid-operation:** a parked redirect and the sticky flag are dropped. The next fetch starts at RESET_PC.

## Timing
- Redirect sampled at edge t → new PC pair visible after edge t (cycle t+1). Redirect latency is 1 cycle.
- `flush_FD` is asserted in cycle t (the accept cycle) only; it is 1 cycle wide per accepted redirect.
- A stall holds PC for exactly the cycles `stall_F` = 1. The advance resumes in the first cycle `stall_F` = 0.
- Parked decode redirect: applied at the first edge where `stall_F` = 0. `flush_FD` pulses in that same cycle.
- `redirect_pending` is registered: it rises the cycle after parking and falls the cycle after apply or discard.

## Structure
- **Shared package `pc_seq_pkg`:**
  - `pc_seq_state_t` enum (BOOT, RUN, STALL, PEND).
  - `redirect_src_t` enum (NONE, TRAP, EX0, EX1, DEC_PEND, DEC).
  - `PC_SLOT_STRIDE` = 4 and `PC_PAIR_STRIDE` = 8.
  - `WIDTH` comes from the common header.
- **Sub-module `redirect_arbiter`:** purely combinational fixed-priority select. Outputs are source, target and the accept strobe.
- **Top level:** holds the FSM, PC registers, pending register and sticky flag.

## Test plan
- **Reset + sequential run:** release `rst`, no redirects, no stall.
  - BOOT cycle: `fetch_valid` = 0.
  - Then the pairs are (0,4), (8,12), (16,20), …
- **Simultaneous redirects:** `trap_vector` = 0x100, `ex_redirect_target_0` = 0x200 and `ex_redirect_target_1` = 0x300, all in the same cycle.
  - Next PC pair is (0x100, 0x104); `flush_FD` pulses once.
  - With `trap_valid` low, the same stimulus gives (0x200, 0x204).
- **Decode redirect under stall:** `dec_redirect_valid` (target 0x40) with `stall_F` = 1 for 3 cycles.
  - PC held; `redirect_pending` = 1.
  - First unstalled cycle: PC = (0x40, 0x44), `flush_FD` = 1, pending clears.
- **Parked redirect superseded:** while in PEND, `ex_redirect_valid_1` with target 0x80.
  - PC = (0x80, 0x84) next cycle despite `stall_F` = 1.
  - The parked 0x40 is never applied.
- **Wrap and misalignment:**
  - PC0 = 32'hFFFF_FFF8 advances to (0, 4).
  - A redirect to 0x103 gives PC (0x100, 0x104) and sets `target_misaligned` until `rst`.
- **Reset mid-PEND:** assert `rst` while parked.
  - Outputs return to reset values; `redirect_pending` = 0.
  - After release, fetch restarts at RESET_PC.
